universal_shift_register_n: RTL and testbench
=============================================

Name: universal_shift_register_n

Overview:
- Parametrised N-bit universal shift register, the successor of the team's 4-bit hold/shift-right/shift-left/load register.
- Adds rotate, arithmetic shift-right, synchronous clear and serial outputs.
- Adds a sequenced "shift by K" operation with a busy/done handshake, so a controller can request a multi-bit shift in one command.
- Sits in the register/counter library as a datapath building block for serialisers and multiplier/divider sequencers.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- CNT_W, 4, width of the shift-count input; maximum sequenced count is 2^CNT_W−1.

Ports:
- CLK  input  1  rising-edge clock
- Clear_b  input  1  asynchronous active-low reset
- mode  input  3  operation select (see Behaviour)
- I_par  input  WIDTH  parallel load data
- MSB_in  input  1  serial input for logical shift-right
- LSB_in  input  1  serial input for shift-left
- start  input  1  request sequenced operation (sampled in IDLE only)
- cnt  input  CNT_W  number of steps for sequenced operation
- A_par  output  WIDTH  register contents
- MSB_out  output  1  equals A_par[WIDTH-1]
- LSB_out  output  1  equals A_par[0]
- busy  output  1  sequenced operation in progress
- done  output  1  one-cycle pulse when sequenced operation completes

Behaviour:
- Reset: Clear_b low asynchronously forces A_par=0, busy=0, done=0, state=IDLE, step counter=0. Reset asserted mid-sequence aborts the sequence; no done pulse is produced.
- Mode encoding:
  - 000 HOLD
  - 001 SHR: A ← {MSB_in, A[W-1:1]}
  - 010 SHL: A ← {A[W-2:0], LSB_in}
  - 011 LOAD: A ← I_par
  - 100 ROR: A ← {A[0], A[W-1:1]}
  - 101 ROL: A ← {A[W-2:0], A[W-1]}
  - 110 ASR: A ← {A[W-1], A[W-1:1]}
  - 111 CLR: A ← 0, synchronous
- FSM states: IDLE, RUN.
- IDLE, start=0: mode is applied on every rising edge (direct operation, latency 1 edge).
- IDLE, start=1, mode in {SHR,SHL,ROR,ROL,ASR}, cnt>0:
  - At that edge, mode is latched into op_q and cnt into a step counter; A_par is unchanged.
  - busy=1 and state goes to RUN.
- IDLE, start=1, cnt=0: no change to A_par; done pulses for the following cycle; busy stays 0.
- IDLE, start=1, mode in {HOLD,LOAD,CLR}: start is ignored; mode is applied directly.
- RUN:
  - Each edge applies op_q once and decrements the counter.
  - MSB_in and LSB_in are sampled live each edge.
  - mode, I_par, start and cnt are ignored.
- RUN exit: on the edge that performs the final step, the FSM returns to IDLE, busy←0 and done←1 for exactly one cycle.
  - Total: edges k+1..k+cnt perform the shifts; busy is high for cnt cycles.
  - start held high at the cycle done is high starts a new sequence at the next edge (back-to-back allowed).
- done is registered; busy and done are never both 1.
- MSB_out and LSB_out are combinational from A_par.
- Rotate and shift wrap: count ≥ WIDTH is permitted. ROR/ROL by WIDTH return the original value; SHL by ≥WIDTH with LSB_in=0 yields 0.

Decomposition:
- Package usr_pkg holds:
  - typedef enum logic [2:0] usr_mode_t for the eight modes above
  - typedef enum state_t {IDLE, RUN}
  - helper function next_value(mode, A, MSB_in, LSB_in) shared by the RTL and the bench reference model
- One natural sub-module: usr_step_counter (loadable CNT_W down-counter with zero flag) instantiated for the RUN sequencing.
- The per-bit datapath stays a generated mux in the top module.

Test Plan (WIDTH=8, CNT_W=4):
- Reset: Clear_b low mid-clock with A_par=8'hFF -> A_par=0, busy=0, done=0 immediately, before the next edge.
- Direct ops:
  - LOAD I_par=8'hA5 -> 8'hA5
  - SHR with MSB_in=1 -> 8'hD2
  - SHL with LSB_in=0 -> 8'hA4
  - ASR on 8'h80 -> 8'hC0
  - CLR -> 8'h00
- Rotate sequence: load 8'h81, start with ROL, cnt=3 -> busy high for 3 cycles, A_par=8'h0C, done pulses once, then busy=0.
- Edge counts:
  - start with cnt=0 -> A_par unchanged, done pulses 1 cycle, busy never high.
  - ROR with cnt=8 on 8'h3C -> 8'h3C.
- Ignore rule: during RUN (SHR, cnt=4 on 8'hF0, MSB_in=0), toggle mode=LOAD and I_par=8'h55 -> result 8'h0F; I_par not loaded.
- Abort and back-to-back:
  - Clear_b pulsed low after the 2nd step of a cnt=5 sequence -> A_par=0, busy=0, no done.
  - start held high across done -> second sequence begins the next edge with busy=1.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types and helpers for the N-bit universal shift register.
//   usr_mode_t  : 3-bit operation select
//   state_t     : sequencer state (IDLE / RUN)
//   is_seq_mode : modes that may be repeated by the sequencer
//   next_value  : one-step reference of a mode on a value up to USR_MAX_W bits
package usr_pkg;

   localparam int unsigned USR_MAX_W = 64;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_SHR  = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_LOAD = 3'b011,
      MODE_ROR  = 3'b100,
      MODE_ROL  = 3'b101,
      MODE_ASR  = 3'b110,
      MODE_CLR  = 3'b111
   } usr_mode_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Modes that make sense to repeat K times.
   function automatic logic is_seq_mode(input usr_mode_t m);
      return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
             (m == MODE_ROL) || (m == MODE_ASR);
   endfunction

   // One step of a mode on the low 'width' bits of 'a'. LOAD has no data
   // operand here, so it returns 'a'; the caller substitutes the load value.
   function automatic logic [USR_MAX_W-1:0] next_value(
      input usr_mode_t               mode,
      input logic [USR_MAX_W-1:0]    a,
      input logic                    msb_in,
      input logic                    lsb_in,
      input int unsigned             width
   );
      logic [USR_MAX_W-1:0] mask;
      logic [USR_MAX_W-1:0] msb_bit;
      logic                 top;
      logic [USR_MAX_W-1:0] r;
      mask    = USR_MAX_W'((65'(1) << width) - 65'(1));
      msb_bit = USR_MAX_W'(1) << (width - 1);
      top     = |(a & msb_bit);
      r       = a;
      case (mode)
         MODE_SHR: r = (a >> 1) | (msb_in ? msb_bit : '0);
         MODE_SHL: r = ((a << 1) | USR_MAX_W'(lsb_in)) & mask;
         MODE_ROR: r = (a >> 1) | (a[0] ? msb_bit : '0);
         MODE_ROL: r = ((a << 1) | USR_MAX_W'(top)) & mask;
         MODE_ASR: r = (a >> 1) | (top ? msb_bit : '0);
         MODE_CLR: r = '0;
         default:  r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/usr_step_counter.sv
// Loadable down-counter used to sequence multi-step shifts.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one, saturating at zero
//   zero_c     : count is zero (combinational from the count register)
module usr_step_counter #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero_c
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_c = (count_q == '0);

endmodule

// File: rtl/universal_shift_register_n.sv
// N-bit universal shift register with sequenced shift-by-K.
//   CLK, Clear_b     : clock, async active-low reset
//   mode             : operation select (usr_mode_t encoding)
//   I_par            : parallel load data
//   MSB_in, LSB_in   : serial inputs for SHR / SHL
//   start, cnt       : request cnt repetitions of a shift/rotate mode
//   A_par            : register contents
//   MSB_out, LSB_out : top / bottom bit of A_par
//   busy             : sequence in progress
//   done             : one-cycle pulse when a sequence completes
module universal_shift_register_n
   import usr_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             CLK,
   input  logic             Clear_b,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] I_par,
   input  logic             MSB_in,
   input  logic             LSB_in,
   input  logic             start,
   input  logic [CNT_W-1:0] cnt,
   output logic [WIDTH-1:0] A_par,
   output logic             MSB_out,
   output logic             LSB_out,
   output logic             busy,
   output logic             done
);

   state_t           state_q, state_d;
   usr_mode_t        op_q, op_d;
   logic [WIDTH-1:0] a_par_q, a_par_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   usr_mode_t        mode_in;
   usr_mode_t        apply_op;
   logic             cnt_load;
   logic             cnt_dec;
   logic             cnt_zero;

   assign mode_in = usr_mode_t'(mode);

   // Counter holds the steps remaining after the current one, so the
   // final step is the one taken while it reads zero.
   usr_step_counter #(
      .CNT_W (CNT_W)
   ) u_step_counter (
      .clk      (CLK),
      .rst_n    (Clear_b),
      .load     (cnt_load),
      .load_val (cnt - CNT_W'(1)),
      .dec      (cnt_dec),
      .zero_c   (cnt_zero)
   );

   // Sequencer: next state, operation to apply this edge, handshake.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      apply_op = MODE_HOLD;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && is_seq_mode(mode_in)) begin
               if (cnt == '0) begin
                  done_d = 1'b1;
               end else begin
                  op_d     = mode_in;
                  cnt_load = 1'b1;
                  busy_d   = 1'b1;
                  state_d  = RUN;
               end
            end else begin
               apply_op = mode_in;
            end
         end
         RUN: begin
            apply_op = op_q;
            if (cnt_zero) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Per-bit datapath mux; end bits take serial inputs or wrap-around.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic up_shr, up_ror, up_asr;
      logic dn_shl, dn_rol;
      logic nxt;

      if (i == WIDTH - 1) begin : g_hi
         assign up_shr = MSB_in;
         assign up_ror = a_par_q[0];
         assign up_asr = a_par_q[WIDTH-1];
      end else begin : g_hi_mid
         assign up_shr = a_par_q[i+1];
         assign up_ror = a_par_q[i+1];
         assign up_asr = a_par_q[i+1];
      end

      if (i == 0) begin : g_lo
         assign dn_shl = LSB_in;
         assign dn_rol = a_par_q[WIDTH-1];
      end else begin : g_lo_mid
         assign dn_shl = a_par_q[i-1];
         assign dn_rol = a_par_q[i-1];
      end

      always_comb begin
         nxt = a_par_q[i];
         case (apply_op)
            MODE_HOLD: nxt = a_par_q[i];
            MODE_SHR:  nxt = up_shr;
            MODE_SHL:  nxt = dn_shl;
            MODE_LOAD: nxt = I_par[i];
            MODE_ROR:  nxt = up_ror;
            MODE_ROL:  nxt = dn_rol;
            MODE_ASR:  nxt = up_asr;
            MODE_CLR:  nxt = 1'b0;
            default:   nxt = a_par_q[i];
         endcase
      end

      assign a_par_d[i] = nxt;
   end

   // State, operation and output registers.
   always_ff @(posedge CLK or negedge Clear_b) begin
      if (!Clear_b) begin
         state_q <= IDLE;
         op_q    <= MODE_HOLD;
         a_par_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_par_q <= a_par_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign A_par   = a_par_q;
   assign MSB_out = a_par_q[WIDTH-1];
   assign LSB_out = a_par_q[0];
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_universal_shift_register_n.sv
// Directed self-checking bench for universal_shift_register_n (WIDTH=8, CNT_W=4).
module tb_universal_shift_register_n;
   import usr_pkg::*;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 4;

   logic             CLK;
   logic             Clear_b;
   logic [2:0]       mode;
   logic [WIDTH-1:0] I_par;
   logic             MSB_in;
   logic             LSB_in;
   logic             start;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] A_par;
   logic             MSB_out;
   logic             LSB_out;
   logic             busy;
   logic             done;

   int n_checks = 0;
   int n_errors = 0;

   universal_shift_register_n #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .CLK     (CLK),
      .Clear_b (Clear_b),
      .mode    (mode),
      .I_par   (I_par),
      .MSB_in  (MSB_in),
      .LSB_in  (LSB_in),
      .start   (start),
      .cnt     (cnt),
      .A_par   (A_par),
      .MSB_out (MSB_out),
      .LSB_out (LSB_out),
      .busy    (busy),
      .done    (done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One rising edge, then settle for sampling.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic direct(input usr_mode_t m, input logic [7:0] par);
      mode  = m;
      I_par = par;
      tick();
      mode  = MODE_HOLD;
   endtask

   // Issue a sequenced op, then watch a bounded number of edges.
   task automatic run_seq(input usr_mode_t m, input logic [3:0] c,
                          input usr_mode_t run_mode, input logic [7:0] run_par,
                          output int busy_cyc, output int done_cyc,
                          output logic [7:0] a_done, output int overlap);
      busy_cyc = 0;
      done_cyc = 0;
      overlap  = 0;
      a_done   = 8'h00;
      mode  = m;
      cnt   = c;
      start = 1'b1;
      for (int k = 0; k < int'(c) + 4; k++) begin
         tick();
         if (k == 0) begin
            start = 1'b0;
            mode  = run_mode;
            I_par = run_par;
         end
         if (busy) busy_cyc++;
         if (done) begin
            done_cyc++;
            a_done = A_par;
            mode   = MODE_HOLD;
         end
         if (busy && done) overlap++;
      end
      mode = MODE_HOLD;
   endtask

   int         bc, dc, ov;
   logic [7:0] ad;
   logic [63:0] ref_v;

   initial begin
      Clear_b = 1'b0;
      mode    = MODE_HOLD;
      I_par   = '0;
      MSB_in  = 1'b0;
      LSB_in  = 1'b0;
      start   = 1'b0;
      cnt     = '0;
      #1;
      chk("rst_a", 32'(A_par), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      #10;
      Clear_b = 1'b1;

      // Async reset mid-clock with register full.
      direct(MODE_LOAD, 8'hFF);
      chk("pre_rst_ff", 32'(A_par), 32'hFF);
      #2 Clear_b = 1'b0;
      #1;
      chk("async_rst_a", 32'(A_par), 32'h0);
      chk("async_rst_busy", 32'(busy), 32'h0);
      chk("async_rst_done", 32'(done), 32'h0);
      #1 Clear_b = 1'b1;

      // Direct operations.
      direct(MODE_LOAD, 8'hA5);
      chk("load_a5", 32'(A_par), 32'hA5);
      chk("msb_out", 32'(MSB_out), 32'h1);
      chk("lsb_out", 32'(LSB_out), 32'h1);
      MSB_in = 1'b1;
      direct(MODE_SHR, 8'h00);
      MSB_in = 1'b0;
      chk("shr_d2", 32'(A_par), 32'hD2);
      chk("lsb_out_0", 32'(LSB_out), 32'h0);
      LSB_in = 1'b0;
      direct(MODE_SHL, 8'h00);
      chk("shl_a4", 32'(A_par), 32'hA4);
      direct(MODE_LOAD, 8'h80);
      direct(MODE_ASR, 8'h00);
      chk("asr_c0", 32'(A_par), 32'hC0);
      direct(MODE_CLR, 8'h00);
      chk("clr_00", 32'(A_par), 32'h00);
      direct(MODE_LOAD, 8'h96);
      direct(MODE_ROR, 8'h00);
      chk("ror_4b", 32'(A_par), 32'h4B);
      ref_v = next_value(MODE_ROL, 64'h4B, 1'b0, 1'b0, WIDTH);
      direct(MODE_ROL, 8'h00);
      chk("rol_ref", 32'(A_par), 32'(ref_v));
      direct(MODE_HOLD, 8'h33);
      chk("hold_96", 32'(A_par), 32'h96);

      // start with a non-shift mode is ignored; LOAD applies directly.
      start = 1'b1;
      cnt   = 4'd3;
      direct(MODE_LOAD, 8'h81);
      start = 1'b0;
      chk("start_ign_load", 32'(A_par), 32'h81);
      chk("start_ign_busy", 32'(busy), 32'h0);

      // ROL by 3 on 0x81 -> 0x0C.
      run_seq(MODE_ROL, 4'd3, MODE_HOLD, 8'h00, bc, dc, ad, ov);
      chk("rol3_a", 32'(ad), 32'h0C);
      chk("rol3_busy_cyc", 32'(bc), 32'd3);
      chk("rol3_done_cyc", 32'(dc), 32'd1);
      chk("rol3_overlap", 32'(ov), 32'd0);
      chk("rol3_busy_end", 32'(busy), 32'h0);

      // cnt=0: no change, single done pulse, never busy.
      run_seq(MODE_SHL, 4'd0, MODE_HOLD, 8'h00, bc, dc, ad, ov);
      chk("cnt0_a", 32'(A_par), 32'h0C);
      chk("cnt0_busy_cyc", 32'(bc), 32'd0);
      chk("cnt0_done_cyc", 32'(dc), 32'd1);

      // ROR by WIDTH returns the original value.
      direct(MODE_LOAD, 8'h3C);
      run_seq(MODE_ROR, 4'd8, MODE_HOLD, 8'h00, bc, dc, ad, ov);
      chk("ror8_a", 32'(ad), 32'h3C);
      chk("ror8_busy_cyc", 32'(bc), 32'd8);
      chk("ror8_done_cyc", 32'(dc), 32'd1);

      // SHL by >= WIDTH with LSB_in=0 clears.
      direct(MODE_LOAD, 8'hFF);
      run_seq(MODE_SHL, 4'd9, MODE_HOLD, 8'h00, bc, dc, ad, ov);
      chk("shl9_a", 32'(ad), 32'h00);

      // mode / I_par ignored while running.
      direct(MODE_LOAD, 8'hF0);
      MSB_in = 1'b0;
      run_seq(MODE_SHR, 4'd4, MODE_LOAD, 8'h55, bc, dc, ad, ov);
      chk("ign_a", 32'(ad), 32'h0F);
      chk("ign_after", 32'(A_par), 32'h0F);
      chk("ign_busy_cyc", 32'(bc), 32'd4);

      // Abort: reset after the 2nd step of a 5-step SHR.
      direct(MODE_LOAD, 8'hAA);
      mode  = MODE_SHR;
      cnt   = 4'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      mode  = MODE_HOLD;
      chk("abort_latch_a", 32'(A_par), 32'hAA);
      tick();
      tick();
      chk("abort_step2_a", 32'(A_par), 32'h2A);
      chk("abort_step2_busy", 32'(busy), 32'h1);
      #2 Clear_b = 1'b0;
      #1;
      chk("abort_a", 32'(A_par), 32'h0);
      chk("abort_busy", 32'(busy), 32'h0);
      #1 Clear_b = 1'b1;
      bc = 0;
      dc = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (busy) bc++;
         if (done) dc++;
      end
      chk("abort_no_done", 32'(dc), 32'd0);
      chk("abort_no_busy", 32'(bc), 32'd0);

      // Back-to-back: start held high across done.
      direct(MODE_LOAD, 8'h01);
      mode  = MODE_ROL;
      cnt   = 4'd2;
      start = 1'b1;
      tick();
      chk("b2b_s0_busy", 32'(busy), 32'h1);
      tick();
      chk("b2b_s1_a", 32'(A_par), 32'h02);
      tick();
      chk("b2b_s2_a", 32'(A_par), 32'h04);
      chk("b2b_s2_done", 32'(done), 32'h1);
      chk("b2b_s2_busy", 32'(busy), 32'h0);
      tick();
      start = 1'b0;
      mode  = MODE_HOLD;
      chk("b2b_s3_busy", 32'(busy), 32'h1);
      chk("b2b_s3_a", 32'(A_par), 32'h04);
      tick();
      tick();
      chk("b2b_s5_a", 32'(A_par), 32'h10);
      chk("b2b_s5_done", 32'(done), 32'h1);
      tick();
      chk("b2b_s6_done", 32'(done), 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
